// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALU ops, mux selects,
// state codes and the control-word payload driven by the state decoder.
package multicycle_control_fsm_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_BRANCH   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALUWB    = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  typedef struct packed {
    logic               mem_to_reg;
    logic               reg_dst;
    logic               ior_d;
    logic               alu_src_a;
    logic               ir_write;
    logic               mem_write;
    logic               mem_read;
    logic               pc_write;
    logic               branch;
    logic               branch_ne;
    logic               reg_write;
    logic               imm_zero_ext;
    logic               illegal_op;
    logic [SEL_W-1:0]   pc_src;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_state_decode.sv
// Purely combinational state-to-control decoder; opcode only refines BRANCH and IEXEC,
// mem_ready only gates the fetch strobes when memory waits are enabled.
module mc_state_decode
  import multicycle_control_fsm_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b0
) (
  input  state_t            state,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output ctrl_t             ctrl_c
);

  logic mem_done;
  assign mem_done = !MEM_WAIT || mem_ready;

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_src    = PCSRC_ALU;
        ctrl_c.ir_write  = mem_done;
        ctrl_c.pc_write  = mem_done;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = SRCB_IMM_SH;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl_c.ior_d    = 1'b1;
        ctrl_c.mem_read = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_c.ior_d     = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_src    = PCSRC_ALUOUT;
        ctrl_c.branch    = (opcode == OP_BEQ);
        ctrl_c.branch_ne = (opcode == OP_BNE);
      end
      S_IEXEC: begin
        ctrl_c.alu_src_a    = 1'b1;
        ctrl_c.alu_src_b    = SRCB_IMM;
        ctrl_c.imm_zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
          OP_ANDI: ctrl_c.alu_op = ALU_AND;
          OP_ORI:  ctrl_c.alu_op = ALU_OR;
          OP_SLTI: ctrl_c.alu_op = ALU_SLT;
          default: ctrl_c.alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        ctrl_c.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_src   = PCSRC_JUMP;
        ctrl_c.pc_write = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_c.illegal_op = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: state register and next-state logic here,
// control outputs come from the combinational state decoder.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit BNE_EN   = 1'b1,
  parameter bit IMM_EN   = 1'b1,
  parameter bit JUMP_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      Opcode,
  input  logic                 mem_ready,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 IorD,
  output logic                 ALUSrcA,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 BranchNe,
  output logic                 RegWrite,
  output logic                 ImmZeroExt,
  output logic                 IllegalOp,
  output logic [SEL_W-1:0]     PCSrc,
  output logic [SEL_W-1:0]     ALUSrcB,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic [STATE_W-1:0]   state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_c;
  logic   mem_done;

  assign mem_done = !MEM_WAIT || mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = BNE_EN ? S_BRANCH : S_ILLEGAL;
          OP_J:         state_d = JUMP_EN ? S_JUMP : S_ILLEGAL;
          default:      state_d = (IMM_EN && is_imm_op(Opcode)) ? S_IEXEC : S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_done ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_done ? S_FETCH : S_MEMWRITE;
      S_EXEC:     state_d = S_ALUWB;
      S_IEXEC:    state_d = S_IWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_state_decode #(
    .MEM_WAIT (MEM_WAIT)
  ) u_decode (
    .state     (state_q),
    .opcode    (Opcode),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl_c)
  );

  assign MemtoReg   = ctrl_c.mem_to_reg;
  assign RegDst     = ctrl_c.reg_dst;
  assign IorD       = ctrl_c.ior_d;
  assign ALUSrcA    = ctrl_c.alu_src_a;
  assign IRWrite    = ctrl_c.ir_write;
  assign MemWrite   = ctrl_c.mem_write;
  assign MemRead    = ctrl_c.mem_read;
  assign PCWrite    = ctrl_c.pc_write;
  assign Branch     = ctrl_c.branch;
  assign BranchNe   = ctrl_c.branch_ne;
  assign RegWrite   = ctrl_c.reg_write;
  assign ImmZeroExt = ctrl_c.imm_zero_ext;
  assign IllegalOp  = ctrl_c.illegal_op;
  assign PCSrc      = ctrl_c.pc_src;
  assign ALUSrcB    = ctrl_c.alu_src_b;
  assign ALUOp      = ctrl_c.alu_op;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: dut0 uses defaults, dut1 has memory waits and bne disabled.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic mem_to_reg, reg_dst, ior_d, alu_src_a, ir_write, mem_write, mem_read;
    logic pc_write, branch, branch_ne, reg_write, imm_zero_ext, illegal_op;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } obs_t;

  typedef struct {
    int          d;
    logic [5:0]  op;
    int          waits;
    int          busy;
    int          wr;
    string       name;
  } vec_t;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_BRANCH = 4'd6, ST_EXEC = 4'd7, ST_ALUWB = 4'd8;
  localparam logic [3:0] ST_IEXEC = 4'd9, ST_IWB = 4'd10, ST_JUMP = 4'd11, ST_ILLEGAL = 4'd12;

  logic clk, rst;
  logic [5:0] op0, op1;
  logic rdy0, rdy1;
  logic mtr0, rdst0, iord0, srca0, irw0, memw0, memr0, pcw0, br0, brne0, rw0, zext0, ill0;
  logic mtr1, rdst1, iord1, srca1, irw1, memw1, memr1, pcw1, br1, brne1, rw1, zext1, ill1;
  logic [1:0] pcsrc0, srcb0, pcsrc1, srcb1;
  logic [2:0] aluop0, aluop1;
  logic [3:0] st0, st1;
  obs_t act0, act1;

  int checks, errors;
  vec_t vq[$];
  logic [5:0] legal_ops[10];

  multicycle_control_fsm #(.MEM_WAIT(1'b0), .BNE_EN(1'b1), .IMM_EN(1'b1), .JUMP_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .Opcode(op0), .mem_ready(rdy0),
    .MemtoReg(mtr0), .RegDst(rdst0), .IorD(iord0), .ALUSrcA(srca0), .IRWrite(irw0),
    .MemWrite(memw0), .MemRead(memr0), .PCWrite(pcw0), .Branch(br0), .BranchNe(brne0),
    .RegWrite(rw0), .ImmZeroExt(zext0), .IllegalOp(ill0), .PCSrc(pcsrc0), .ALUSrcB(srcb0),
    .ALUOp(aluop0), .state_o(st0));

  multicycle_control_fsm #(.MEM_WAIT(1'b1), .BNE_EN(1'b0), .IMM_EN(1'b1), .JUMP_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .Opcode(op1), .mem_ready(rdy1),
    .MemtoReg(mtr1), .RegDst(rdst1), .IorD(iord1), .ALUSrcA(srca1), .IRWrite(irw1),
    .MemWrite(memw1), .MemRead(memr1), .PCWrite(pcw1), .Branch(br1), .BranchNe(brne1),
    .RegWrite(rw1), .ImmZeroExt(zext1), .IllegalOp(ill1), .PCSrc(pcsrc1), .ALUSrcB(srcb1),
    .ALUOp(aluop1), .state_o(st1));

  assign act0 = {st0, mtr0, rdst0, iord0, srca0, irw0, memw0, memr0, pcw0, br0, brne0,
                 rw0, zext0, ill0, pcsrc0, srcb0, aluop0};
  assign act1 = {st1, mtr1, rdst1, iord1, srca1, irw1, memw1, memr1, pcw1, br1, brne1,
                 rw1, zext1, ill1, pcsrc1, srcb1, aluop1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word each state must present, taken straight from the state descriptions.
  function automatic obs_t expect_obs(input logic [3:0] ph, input logic [5:0] op,
                                      input logic rdy, input bit mw);
    obs_t e;
    e = '0;
    e.st = ph;
    case (ph)
      ST_FETCH: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        e.ir_write = mw ? rdy : 1'b1; e.pc_write = mw ? rdy : 1'b1;
      end
      ST_DECODE:   e.alu_src_b = 2'b11;
      ST_MEMADR:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      ST_MEMREAD:  begin e.ior_d = 1'b1; e.mem_read = 1'b1; end
      ST_MEMWRITE: begin e.ior_d = 1'b1; e.mem_write = 1'b1; end
      ST_MEMWB:    begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      ST_EXEC:     begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
      ST_ALUWB:    begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      ST_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01;
        e.branch = (op == 6'b000100); e.branch_ne = (op == 6'b000101);
      end
      ST_IEXEC: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 :
                   (op == 6'b001010) ? 3'b101 : 3'b000;
        e.imm_zero_ext = (op == 6'b001100) || (op == 6'b001101);
      end
      ST_IWB:      e.reg_write = 1'b1;
      ST_JUMP:     begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      ST_ILLEGAL:  e.illegal_op = 1'b1;
      default:     e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input int d, input logic [3:0] ph, input string name);
    obs_t e, a;
    e = expect_obs(ph, (d == 0) ? op0 : op1, (d == 0) ? rdy0 : rdy1, d == 1);
    a = (d == 0) ? act0 : act1;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, d, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic [5:0] o, input logic r);
    if (d == 0) begin op0 = o; rdy0 = r; end
    else begin op1 = o; rdy1 = r; end
  endtask

  // Holds reset across an edge so both DUTs leave reset aligned in FETCH.
  task automatic do_reset();
    rst = 1'b0;
    rdy0 = 1'($urandom);
    rdy1 = 1'($urandom);
    #2;
    chk(0, ST_FETCH, "reset_hold");
    chk(1, ST_FETCH, "reset_hold");
    step();
    chk(0, ST_FETCH, "reset_edge");
    chk(1, ST_FETCH, "reset_edge");
    rst = 1'b1;
  endtask

  // Reference: the phase list of one instruction, memory phases stretched by the wait count.
  task automatic run_instr(input int d, input logic [5:0] op, input int waits,
                           input string name, output int busy, output int wr);
    logic [3:0] seq[$];
    bit mw, bne_en, memph;
    int n;
    logic r;
    mw = (d == 1);
    bne_en = (d == 0);
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (op)
      6'b100011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMREAD); seq.push_back(ST_MEMWB); end
      6'b101011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWRITE); end
      6'b000000: begin seq.push_back(ST_EXEC); seq.push_back(ST_ALUWB); end
      6'b000100: seq.push_back(ST_BRANCH);
      6'b000101: seq.push_back(bne_en ? ST_BRANCH : ST_ILLEGAL);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin seq.push_back(ST_IEXEC); seq.push_back(ST_IWB); end
      6'b000010: seq.push_back(ST_JUMP);
      default:   seq.push_back(ST_ILLEGAL);
    endcase
    busy = 0;
    wr = 0;
    foreach (seq[i]) begin
      memph = (seq[i] == ST_FETCH) || (seq[i] == ST_MEMREAD) || (seq[i] == ST_MEMWRITE);
      n = (memph && mw) ? waits + 1 : 1;
      for (int k = 0; k < n; k++) begin
        r = (memph && mw) ? (k == waits) : 1'($urandom);
        set_in(d, (seq[i] == ST_FETCH) ? 6'($urandom) : op, r);
        #3;
        chk(d, seq[i], name);
        if (((d == 0) ? act0.st : act1.st) != ST_FETCH) busy++;
        if ((d == 0) ? act0.reg_write : act1.reg_write) wr++;
        step();
      end
    end
  endtask

  task automatic add_vec(input int d, input logic [5:0] op, input int waits,
                         input int busy, input int wr, input string name);
    vec_t v;
    v.d = d; v.op = op; v.waits = waits; v.busy = busy; v.wr = wr; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    int cur_d, busy, wr, d, sel, waits;
    logic [5:0] op;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    op0 = '0; op1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011; legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100; legal_ops[4] = 6'b000101; legal_ops[5] = 6'b001000;
    legal_ops[6] = 6'b001100; legal_ops[7] = 6'b001101; legal_ops[8] = 6'b001010;
    legal_ops[9] = 6'b000010;

    // {dut, opcode, waits, cycles outside FETCH, RegWrite pulses, name}
    add_vec(0, 6'b000000, 0, 3, 1, "rtype");
    add_vec(1, 6'b100011, 3, 7, 1, "lw_wait3");
    add_vec(0, 6'b001101, 0, 3, 1, "ori");
    add_vec(0, 6'b111111, 0, 2, 0, "illegal_3f");
    add_vec(1, 6'b000101, 0, 2, 0, "bne_disabled");
    add_vec(0, 6'b000010, 0, 2, 0, "jump");
    add_vec(0, 6'b000101, 0, 2, 0, "bne");
    add_vec(0, 6'b000100, 0, 2, 0, "beq");
    add_vec(1, 6'b101011, 2, 5, 0, "sw_wait2");
    add_vec(0, 6'b001010, 0, 3, 1, "slti");
    add_vec(0, 6'b001100, 0, 3, 1, "andi");
    add_vec(0, 6'b001000, 0, 3, 1, "addi");
    add_vec(0, 6'b100011, 0, 4, 1, "lw");
    add_vec(0, 6'b101011, 0, 3, 0, "sw");
    add_vec(1, 6'b001101, 1, 3, 1, "ori_wait");

    step();
    do_reset();
    cur_d = -1;
    foreach (vq[i]) begin
      if (vq[i].d != cur_d) begin
        do_reset();
        cur_d = vq[i].d;
      end
      run_instr(vq[i].d, vq[i].op, vq[i].waits, vq[i].name, busy, wr);
      chk_int({vq[i].name, "_busy"}, busy, vq[i].busy);
      chk_int({vq[i].name, "_regwrite"}, wr, vq[i].wr);
    end

    // Asynchronous reset between edges while a store is stalled in MEMWRITE.
    do_reset();
    set_in(1, 6'($urandom), 1'b1); #3; chk(1, ST_FETCH, "sw_fetch"); step();
    set_in(1, 6'b101011, 1'($urandom)); #3; chk(1, ST_DECODE, "sw_decode"); step();
    #3; chk(1, ST_MEMADR, "sw_memadr"); step();
    set_in(1, 6'b101011, 1'b0); #3; chk(1, ST_MEMWRITE, "sw_stall"); step();
    #3; chk(1, ST_MEMWRITE, "sw_stall_hold");
    #1; rst = 1'b0;
    #1; chk(1, ST_FETCH, "async_rst_dut1"); chk(0, ST_FETCH, "async_rst_dut0");
    #1; rst = 1'b1; rdy1 = 1'b1;
    #1; chk(1, ST_FETCH, "rst_release_fetch");
    step();
    set_in(1, 6'b000000, 1'b0); #3; chk(1, ST_DECODE, "first_edge_after_rst");
    step();

    do_reset();
    cur_d = -1;
    for (int t = 0; t < 80; t++) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 11));
      waits = int'($urandom_range(0, 3));
      if (sel < 10) op = legal_ops[sel];
      else if (sel == 10) op = 6'b111111;
      else op = 6'($urandom);
      if (d != cur_d) begin
        do_reset();
        cur_d = d;
      end
      run_instr(d, op, waits, "random", busy, wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
